control_sequencer: RTL
======================

Name: control_sequencer

Overview:
Microcode sequencer for the 8-bit machine built from our 74xx models. It holds the T-step counter and decodes the instruction-register opcode plus carry/zero flags into the 16-bit control word. That word drives the load/enable pins of the '173 registers, '189 RAM, '163 program counter, '283 ALU subtract input and the '244 bus drivers, so this block sits directly upstream of every datapath chip.

Parameters:
OPW, 4, opcode width in bits (upper nibble of the instruction register)
STEPW, 3, step counter width in bits
STEPS, 5, step count; the counter wraps to 0 after step STEPS-1

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears step and halted immediately
step_en  input  1  clock enable for manual single-step or run; 0 freezes all state
opcode  input  OPW  current instruction opcode from the instruction register
cf  input  1  carry flag from the flags register
zf  input  1  zero flag from the flags register
cw  output  16  control word: [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO [7]EO [6]SU [5]BI [4]OI [3]CE [2]CO [1]J [0]FI
step  output  STEPW  current T-step
halted  output  1  halt latch

Behaviour:
- One clock domain. Reset is asynchronous and active-high; clock port is clk, reset port is reset.
- While reset is high: step=0, halted=0, and therefore cw=16'h4004 (CO|MI).
- cw is combinational from {halted, opcode, cf, zf, step}. Zero latency: it changes in the same cycle as step or opcode.
- Fetch steps, identical for all opcodes:
  - step 0: CO|MI = 16'h4004
  - step 1: RO|II|CE = 16'h1408
- Execute steps (per opcode; unlisted steps are 0):
  - LDA 1: step 2 IO|MI = 4800, step 3 RO|AI = 1200
  - ADD 2: step 2 4800, step 3 RO|BI = 1020, step 4 EO|AI|FI = 0281
  - SUB 3: step 2 4800, step 3 1020, step 4 EO|AI|SU|FI = 02C1
  - STA 4: step 2 4800, step 3 AO|RI = 2100
  - LDI 5: step 2 IO|AI = 0A00
  - JMP 6: step 2 IO|J = 0802
  - JC 7: step 2 = 0802 if cf, else 0000
  - JZ 8: step 2 = 0802 if zf, else 0000
  - OUT E: step 2 AO|OI = 0110
  - HLT F: step 2 HLT = 8000
  - NOP 0 and undefined 9–D: step 2 = 0000
- Each ROM entry carries an internal "done" bit on its last step. Minimum instruction length is 3 steps; the last step is step 2, 3 or 4 per the list above.
- Step update on a rising clk edge with step_en=1 and halted=0:
  - step becomes 0 if the current entry has done set or step==STEPS-1;
  - otherwise step increments by 1.
  - Unsigned, STEPW wide; step never exceeds STEPS-1.
- Halt: on a rising edge with step_en=1, halted=0 and the current cw bit 15 set, halted becomes 1 and step holds.
- While halted=1: cw is forced to 16'h8000 and step is frozen. Only reset clears halted.
- step_en=0: step and halted hold; cw still tracks opcode and flag changes combinationally.
- cf/zf are consumed only by the JC/JZ step-2 entries. A flag change mid-step alters cw within that cycle.
- Reset asserted mid-instruction (any step, clock running or not): state clears without waiting for a clock edge; the next instruction starts at fetch step 0 after reset deasserts.

Decomposition:
- Shared package holds:
  - control-bit index constants (HLT..FI);
  - opcode constants (NOP, LDA, ADD, SUB, STA, LDI, JMP, JC, JZ, OUT, HLT);
  - STEPS default.
- Sub-module microcode_rom: purely combinational. Inputs {opcode, cf, zf, step}; outputs {cw_raw[15:0], done}.
- control_sequencer holds the step counter, halt latch and halted override.

Test Plan:
- Reset: pulse reset with no clk edges -> step=0, halted=0, cw=4004; release, one edge -> step=1, cw=1408.
- ADD: opcode=2, step_en=1 -> cw sequence 4004, 1408, 4800, 1020, 0281, then 4004 (step wraps 4->0).
- Conditional jump, opcode=7:
  - cf=0: step-2 cw=0000, next edge gives step=0 (3-cycle instruction);
  - cf=1: step-2 cw=0802.
  - Repeat for JZ with zf.
- Halt: opcode=F -> step 2 cw=8000; after the edge halted=1, and 20 further edges keep step=2, cw=8000; reset returns cw=4004.
- Freeze: step_en=0 for 10 edges at step 3 of STA -> step stays 3, cw=2100; then assert reset between edges -> step=0 immediately.
- Short opcodes: LDI 5 -> step 2 cw=0A00 then wrap; OUT E -> 0110 then wrap; undefined 0xB -> 0000 then wrap.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared constants for the microcode sequencer: control-word bit positions,
// opcode encodings and the default instruction step count.
package control_sequencer_pkg;

  localparam int STEPS_DEF = 5;

  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic [15:0] cwb(input int idx);
    logic [15:0] w;
    w      = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode table: {opcode, flags, step} -> raw control word
// plus a done marker on each instruction's final step.
module microcode_rom
  import control_sequencer_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int STEPW = 3
) (
  input  logic [OPW-1:0]   opcode,
  input  logic             cf,
  input  logic             zf,
  input  logic [STEPW-1:0] step,
  output logic [15:0]      cw_raw,
  output logic             done
);

  logic [3:0] op;
  assign op = 4'(opcode);

  always_comb begin
    cw_raw = '0;
    done   = 1'b0;
    case (int'(step))
      0: cw_raw = cwb(B_CO) | cwb(B_MI);
      1: cw_raw = cwb(B_RO) | cwb(B_II) | cwb(B_CE);
      2: begin
        done = 1'b1;
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw_raw = cwb(B_IO) | cwb(B_MI);
            done   = 1'b0;
          end
          OP_LDI:  cw_raw = cwb(B_IO) | cwb(B_AI);
          OP_JMP:  cw_raw = cwb(B_IO) | cwb(B_J);
          OP_JC:   cw_raw = cf ? (cwb(B_IO) | cwb(B_J)) : '0;
          OP_JZ:   cw_raw = zf ? (cwb(B_IO) | cwb(B_J)) : '0;
          OP_OUT:  cw_raw = cwb(B_AO) | cwb(B_OI);
          OP_HLT:  cw_raw = cwb(B_HLT);
          default: cw_raw = '0;
        endcase
      end
      3: begin
        done = 1'b1;
        case (op)
          OP_LDA: cw_raw = cwb(B_RO) | cwb(B_AI);
          OP_ADD, OP_SUB: begin
            cw_raw = cwb(B_RO) | cwb(B_BI);
            done   = 1'b0;
          end
          OP_STA:  cw_raw = cwb(B_AO) | cwb(B_RI);
          default: cw_raw = '0;
        endcase
      end
      4: begin
        done = 1'b1;
        case (op)
          OP_ADD:  cw_raw = cwb(B_EO) | cwb(B_AI) | cwb(B_FI);
          OP_SUB:  cw_raw = cwb(B_EO) | cwb(B_AI) | cwb(B_SU) | cwb(B_FI);
          default: cw_raw = '0;
        endcase
      end
      // unreachable steps end the instruction so the counter can never stick
      default: done = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// T-step counter and halt latch in front of the microcode ROM; a latched
// halt overrides the control word with HLT until reset.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int STEPW = 3,
  parameter int STEPS = STEPS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic [OPW-1:0]   opcode,
  input  logic             cf,
  input  logic             zf,
  output logic [15:0]      cw,
  output logic [STEPW-1:0] step,
  output logic             halted
);

  logic [STEPW-1:0] step_q, step_d;
  logic             halted_q, halted_d;
  logic [15:0]      cw_raw;
  logic             done;

  microcode_rom #(.OPW(OPW), .STEPW(STEPW)) u_rom (
    .opcode (opcode),
    .cf     (cf),
    .zf     (zf),
    .step   (step_q),
    .cw_raw (cw_raw),
    .done   (done)
  );

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (step_en && !halted_q) begin
      if (cw_raw[B_HLT])
        halted_d = 1'b1;
      else if (done || step_q == STEPW'(STEPS - 1))
        step_d = '0;
      else
        step_d = step_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign cw     = halted_q ? cwb(B_HLT) : cw_raw;
  assign step   = step_q;
  assign halted = halted_q;

endmodule
